// File: rtl/cosim_job_arbiter.sv
// Round-robin arbiter sharing one cosine-similarity engine among NREQ requesters.
// Optional engine watchdog: define COSIM_ARB_TIMEOUT_EN (TIMEOUT parameter exists only then).
//
// state  | meaning
// IDLE   | arbitrate from ptr, accept the winning request
// LAUNCH | pulse eng_start; latched vectors already on the engine
// WAIT   | hold vectors, wait for eng_valid (or watchdog abort)
// RESP   | present result to grant_id until its rsp_ready
module cosim_job_arbiter #(
  parameter int NREQ = 4,
  parameter int W = 5,
`ifdef COSIM_ARB_TIMEOUT_EN
  parameter int TIMEOUT = 64,
`endif
  parameter int IDW = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*W*32-1:0]   req_vec_a,
  input  logic [NREQ*W*32-1:0]   req_vec_b,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [31:0]            rsp_result,
  output logic                   rsp_error,
  output logic                   eng_start,
  output logic [W*32-1:0]        eng_vec_a,
  output logic [W*32-1:0]        eng_vec_b,
  input  logic [31:0]            eng_similarity,
  input  logic                   eng_valid,
  output logic                   busy,
  output logic [IDW-1:0]         grant_id
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [W*32-1:0] vec_a_q, vec_a_d;
  logic [W*32-1:0] vec_b_q, vec_b_d;
  logic [31:0]     result_q, result_d;
  logic [IDW-1:0]  win, cand;
  logic            found;

  logic [W*32-1:0] vec_a_arr [NREQ];
  logic [W*32-1:0] vec_b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_split
    assign vec_a_arr[g] = req_vec_a[g*W*32 +: W*32];
    assign vec_b_arr[g] = req_vec_b[g*W*32 +: W*32];
  end

  // Scan from the highest offset down so the candidate closest to ptr wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      cand = IDW'((int'(ptr_q) + j) % NREQ);
      if (req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

`ifdef COSIM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] wd_q, wd_d;
  logic          err_q, err_d;
  logic          wd_expired;

  assign wd_expired = (wd_q == CW'(TIMEOUT - 1));

  always_comb begin
    wd_d  = wd_q;
    err_d = err_q;
    if (state_q == S_LAUNCH) begin
      wd_d = '0;
    end else if (state_q == S_WAIT) begin
      wd_d = wd_q + 1'b1;
      if (eng_valid)       err_d = 1'b0;
      else if (wd_expired) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign rsp_error = err_q;
`else
  assign rsp_error = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    vec_a_d    = vec_a_q;
    vec_b_d    = vec_b_q;
    result_d   = result_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          vec_a_d    = vec_a_arr[win];
          vec_b_d    = vec_b_arr[win];
          grant_id_d = win;
          ptr_d      = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
          state_d    = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (eng_valid) begin
          result_d = eng_similarity;
          state_d  = S_RESP;
        end
`ifdef COSIM_ARB_TIMEOUT_EN
        else if (wd_expired) begin
          result_d = 32'h7FC0_0000;
          state_d  = S_RESP;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready[grant_id_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      vec_a_q    <= '0;
      vec_b_q    <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      vec_a_q    <= vec_a_d;
      vec_b_q    <= vec_b_d;
      result_q   <= result_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE && found) ? (NREQ'(1) << win) : '0;
  assign rsp_valid  = (state_q == S_RESP) ? (NREQ'(1) << grant_id_q) : '0;
  assign rsp_result = result_q;
  assign eng_start  = (state_q == S_LAUNCH);
  assign eng_vec_a  = vec_a_q;
  assign eng_vec_b  = vec_b_q;
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = grant_id_q;

endmodule
